// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv2d frame path: default frame geometry, the
// derived counts and address widths, the controller state encoding and a
// helper that sizes address buses.
// Ports: none (package).
// -----------------------------------------------------------------------------
package conv_pkg;

  // Address width for a memory of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default frame geometry (5x5 image, 3x3 kernel).
  localparam int DEF_IMG_W = 5;
  localparam int DEF_IMG_H = 5;
  localparam int DEF_K     = 3;

  localparam int OUT_W  = DEF_IMG_W - DEF_K + 1;
  localparam int OUT_H  = DEF_IMG_H - DEF_K + 1;
  localparam int N_IN   = DEF_IMG_W * DEF_IMG_H;
  localparam int N_OUT  = OUT_W * OUT_H;
  localparam int IN_AW  = addr_w(N_IN);
  localparam int OUT_AW = addr_w(N_OUT);
  localparam int CNT_W  = addr_w(N_OUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/conv_fmap_buf.sv
// -----------------------------------------------------------------------------
// conv_fmap_buf
// Feature-map buffer: one write port, one registered read port.
// Ports:
//   clk, rst       clock, synchronous active-high reset (read register only)
//   we/waddr/wdata write strobe, index and signed result word
//   raddr          read index; out-of-range indices read back as 0
//   rdata          registered read data, one cycle after raddr
// -----------------------------------------------------------------------------
module conv_fmap_buf
  import conv_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [ACC_W-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [ACC_W-1:0] rdata
);

  logic signed [ACC_W-1:0] mem_r [DEPTH];
  logic signed [ACC_W-1:0] rdata_r;
  logic                    rd_in_range_s;

  // Range check for the read index.
  always_comb begin
    rd_in_range_s = ({1'b0, raddr} < (AW + 1)'(DEPTH));
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (rd_in_range_s) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/conv_stream_ctrl.sv
// -----------------------------------------------------------------------------
// conv_stream_ctrl
// Holds one IMG_H x IMG_W frame, streams it in raster order to conv2d over a
// valid/ready handshake and collects the OUT_H x OUT_W results into a
// feature-map buffer.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data       frame write port (only while not busy)
//   start                       pulse that begins a frame from IDLE or DONE
//   pix_valid/pix_ready         pixel handshake, pixel_out is the payload
//   res_valid/conv_out          result stream from conv2d
//   rd_addr/rd_data             feature-map read, one-cycle latency
//   busy, done, res_count       status; overflow is a sticky error flag
// -----------------------------------------------------------------------------
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  localparam int N_PIX  = IMG_W * IMG_H,
  localparam int N_RES  = (IMG_W - K + 1) * (IMG_H - K + 1),
  localparam int PIX_AW = addr_w(N_PIX),
  localparam int RES_AW = addr_w(N_RES),
  localparam int RC_W   = addr_w(N_RES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic [PIX_AW-1:0]       ld_addr,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic                    start,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [DATA_W-1:0]       pixel_out,
  input  logic                    res_valid,
  input  logic signed [ACC_W-1:0] conv_out,
  input  logic [RES_AW-1:0]       rd_addr,
  output logic signed [ACC_W-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [RC_W-1:0]         res_count,
  output logic                    overflow
);

  state_e              state_r;
  logic [DATA_W-1:0]   mem_r [N_PIX];
  logic [PIX_AW-1:0]   in_idx_r;
  logic                pix_valid_r;
  logic [DATA_W-1:0]   pixel_out_r;
  logic                busy_r;
  logic                done_r;
  logic                overflow_r;
  logic [RC_W-1:0]     res_count_r;

  logic                idle_s;
  logic                xfer_s;
  logic                last_pix_s;
  logic [PIX_AW-1:0]   nxt_idx_s;
  logic                room_s;
  logic                cap_s;
  logic                res_done_s;
  logic                ld_ok_s;

  // Handshake, capture and load qualifiers derived from current state.
  always_comb begin
    idle_s     = (state_r == IDLE) || (state_r == DONE);
    xfer_s     = pix_valid_r && pix_ready;
    last_pix_s = (in_idx_r == PIX_AW'(N_PIX - 1));
    nxt_idx_s  = in_idx_r + PIX_AW'(1);
    room_s     = (res_count_r < RC_W'(N_RES));
    cap_s      = res_valid && !idle_s && room_s;
    // All results in hand, either already or with this cycle's capture.
    res_done_s = !room_s || (cap_s && (res_count_r == RC_W'(N_RES - 1)));
    ld_ok_s    = ld_en && idle_s && ({1'b0, ld_addr} < (PIX_AW + 1)'(N_PIX));
  end

  // Frame memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // Frame controller FSM with pixel feeder and result counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_idx_r    <= '0;
      pix_valid_r <= 1'b0;
      pixel_out_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      res_count_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r     <= STREAM;
            in_idx_r    <= '0;
            pix_valid_r <= 1'b1;
            pixel_out_r <= mem_r[0];
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            res_count_r <= '0;
            // A result arriving with start is charged to the new frame.
            overflow_r  <= res_valid;
          end else begin
            overflow_r  <= overflow_r | res_valid;
          end
        end
        STREAM: begin
          if (cap_s) begin
            res_count_r <= res_count_r + RC_W'(1);
          end else if (res_valid) begin
            overflow_r  <= 1'b1;
          end
          if (xfer_s) begin
            if (last_pix_s) begin
              pix_valid_r <= 1'b0;
              if (res_done_s) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r <= DRAIN;
              end
            end else begin
              in_idx_r    <= nxt_idx_s;
              pixel_out_r <= mem_r[nxt_idx_s];
            end
          end
        end
        DRAIN: begin
          if (cap_s) begin
            res_count_r <= res_count_r + RC_W'(1);
            if (res_done_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else if (res_valid) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          pix_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  conv_fmap_buf #(
    .ACC_W (ACC_W),
    .DEPTH (N_RES),
    .AW    (RES_AW)
  ) u_fmap_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_s),
    .waddr (res_count_r[RES_AW-1:0]),
    .wdata (conv_out),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign pix_valid = pix_valid_r;
  assign pixel_out = pixel_out_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign overflow  = overflow_r;
  assign res_count = res_count_r;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_ctrl
// Self-checking bench for conv_stream_ctrl: a default 5x5/3x3 instance driven
// by a behavioural conv2d model, plus a 6x4/3x3 instance for geometry.
// -----------------------------------------------------------------------------
module tb_conv_stream_ctrl;

  localparam int IW = 5, IH = 5, KK = 3;
  localparam int OW = IW - KK + 1, OH = IH - KK + 1;
  localparam int NI = IW * IH, NO = OW * OH;
  localparam int IW6 = 6, IH6 = 4;
  localparam int NI6 = IW6 * IH6, NO6 = (IW6 - KK + 1) * (IH6 - KK + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               ld_en = 1'b0;
  logic [4:0]         ld_addr = 5'd0;
  logic [7:0]         ld_data = 8'd0;
  logic               start = 1'b0;
  logic               pix_valid;
  logic               pix_ready = 1'b0;
  logic [7:0]         pixel_out;
  logic               res_valid = 1'b0;
  logic signed [31:0] conv_out = 32'sd0;
  logic [3:0]         rd_addr = 4'd0;
  logic signed [31:0] rd_data;
  logic               busy, done, overflow;
  logic [3:0]         res_count;

  logic               ld_en6 = 1'b0;
  logic [4:0]         ld_addr6 = 5'd0;
  logic [7:0]         ld_data6 = 8'd0;
  logic               start6 = 1'b0;
  logic               pix_valid6;
  logic               pix_ready6 = 1'b0;
  logic [7:0]         pixel_out6;
  logic               res_valid6 = 1'b0;
  logic signed [31:0] conv_out6 = 32'sd0;
  logic [2:0]         rd_addr6 = 3'd0;
  logic signed [31:0] rd_data6;
  logic               busy6, done6, overflow6;
  logic [3:0]         res_count6;

  conv_stream_ctrl dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pixel_out(pixel_out), .res_valid(res_valid), .conv_out(conv_out),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .res_count(res_count), .overflow(overflow)
  );

  conv_stream_ctrl #(.IMG_W(IW6), .IMG_H(IH6), .K(KK)) dut6 (
    .clk(clk), .rst(rst), .ld_en(ld_en6), .ld_addr(ld_addr6), .ld_data(ld_data6),
    .start(start6), .pix_valid(pix_valid6), .pix_ready(pix_ready6),
    .pixel_out(pixel_out6), .res_valid(res_valid6), .conv_out(conv_out6),
    .rd_addr(rd_addr6), .rd_data(rd_data6), .busy(busy6), .done(done6),
    .res_count(res_count6), .overflow(overflow6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] img [NI];
  int streamed[$];
  int pend[$];
  int stall_viol, first_cyc, last_cyc;

  // Expected feature-map value for output (r,c): all-ones kernel window sum.
  function automatic int exp_res(input int r, input int c);
    int s = 0;
    for (int a = 0; a < KK; a++)
      for (int b = 0; b < KK; b++)
        s += int'(img[(r + a) * IW + c + b]);
    return s;
  endfunction

  task automatic load_frame();
    for (int i = 0; i < NI; i++) begin
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = img[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // Starts a frame and plays conv2d until done, a budget, or pixel abort_at
  // is presented. disturb adds spurious start pulses and loads while busy.
  task automatic run_frame(input bit rand_ready, input bit disturb,
                           input int abort_at, output bit timed_out);
    bit prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'd0;
    int idx, r, c, s;
    streamed.delete(); pend.delete();
    stall_viol = 0; first_cyc = -1; last_cyc = -1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin timed_out = 1'b0; break; end
      if (abort_at >= 0 && pix_valid && streamed.size() == abort_at) begin
        timed_out = 1'b0; break;
      end
      if (prev_stall && pixel_out !== prev_pix) stall_viol++;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        res_valid = 1'b1; conv_out = pend.pop_front();
      end else begin
        res_valid = 1'b0; conv_out = 32'sd0;
      end
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        ld_en = 1'($urandom_range(0, 1));
        ld_addr = 5'($urandom_range(0, NI - 1));
        ld_data = 8'($urandom);
      end
      if (pix_valid && first_cyc < 0) first_cyc = cyc;
      if (pix_valid && pix_ready) begin
        streamed.push_back(int'(pixel_out));
        last_cyc = cyc;
        idx = streamed.size() - 1;
        r = idx / IW; c = idx % IW;
        if (r >= KK - 1 && c >= KK - 1) begin
          s = 0;
          for (int a = 0; a < KK; a++)
            for (int b = 0; b < KK; b++)
              s += streamed[(r - KK + 1 + a) * IW + (c - KK + 1 + b)];
          pend.push_back(s);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix = pixel_out;
      @(negedge clk);
    end
    res_valid = 1'b0; conv_out = 32'sd0; pix_ready = 1'b0;
    start = 1'b0; ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    n_cmp++; if (pixel_out !== 8'd0) begin n_bad++; $display("FAIL reset_pixel_out: got %0d want 0", pixel_out); end
    n_cmp++; if ({busy, done, overflow} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
    n_cmp++; if (res_count !== 4'd0) begin n_bad++; $display("FAIL reset_res_count: got %0d want 0", res_count); end
    n_cmp++; if (rd_data !== 32'sd0) begin n_bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    int bad_order = 0;
    for (int i = 0; i < NI; i++) img[i] = 8'(i);
    load_frame();
    run_frame(1'b0, 1'b0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_cmp++; if (streamed.size() != NI) begin n_bad++; $display("FAIL basic_xfers: got %0d want %0d", streamed.size(), NI); end
    for (int i = 0; i < streamed.size() && i < NI; i++) if (streamed[i] != i) bad_order++;
    n_cmp++; if (bad_order != 0) begin n_bad++; $display("FAIL basic_order: got %0d misordered want 0", bad_order); end
    n_cmp++; if (first_cyc != 0 || last_cyc != NI - 1) begin n_bad++; $display("FAIL basic_throughput: got %0d..%0d want 0..%0d", first_cyc, last_cyc, NI - 1); end
    n_cmp++; if ({done, busy, overflow} !== 3'b100) begin n_bad++; $display("FAIL basic_flags: got %b want 100", {done, busy, overflow}); end
    n_cmp++; if (res_count !== 4'(NO)) begin n_bad++; $display("FAIL basic_res_count: got %0d want %0d", res_count, NO); end
    for (int i = 0; i < NO; i++) begin
      rd_addr = 4'(i); @(negedge clk);
      n_cmp++; if (rd_data !== exp_res(i / OW, i % OW)) begin n_bad++; $display("FAIL basic_buf[%0d]: got %0d want %0d", i, rd_data, exp_res(i / OW, i % OW)); end
    end
  endtask

  task automatic test_stall();
    bit to;
    int bad_order = 0;
    for (int i = 0; i < NI; i++) img[i] = 8'($urandom);
    load_frame();
    run_frame(1'b1, 1'b0, -1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got %b want 0", to); end
    n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
    n_cmp++; if (streamed.size() != NI) begin n_bad++; $display("FAIL stall_xfers: got %0d want %0d", streamed.size(), NI); end
    for (int i = 0; i < streamed.size() && i < NI; i++) if (streamed[i] != int'(img[i])) bad_order++;
    n_cmp++; if (bad_order != 0) begin n_bad++; $display("FAIL stall_order: got %0d misordered want 0", bad_order); end
    for (int i = 0; i < NO; i++) begin
      rd_addr = 4'(i); @(negedge clk);
      n_cmp++; if (rd_data !== exp_res(i / OW, i % OW)) begin n_bad++; $display("FAIL stall_buf[%0d]: got %0d want %0d", i, rd_data, exp_res(i / OW, i % OW)); end
    end
  endtask

  task automatic test_overflow();
    res_valid = 1'b1; conv_out = -32'sd7; @(negedge clk);
    res_valid = 1'b0; conv_out = 32'sd0;
    n_cmp++; if ({overflow, done} !== 2'b11) begin n_bad++; $display("FAIL ovf_flag: got %b want 11", {overflow, done}); end
    rd_addr = 4'd8; @(negedge clk);
    n_cmp++; if (rd_data !== exp_res(2, 2)) begin n_bad++; $display("FAIL ovf_buf8: got %0d want %0d", rd_data, exp_res(2, 2)); end
    rd_addr = 4'd12; @(negedge clk);
    n_cmp++; if (rd_data !== 32'sd0) begin n_bad++; $display("FAIL ovf_rd_oob: got %0d want 0", rd_data); end
    pix_ready = 1'b0; start = 1'b1; @(negedge clk); start = 1'b0;
    n_cmp++; if ({overflow, done, busy, pix_valid} !== 4'b0011) begin n_bad++; $display("FAIL ovf_restart: got %b want 0011", {overflow, done, busy, pix_valid}); end
    n_cmp++; if (pixel_out !== img[0]) begin n_bad++; $display("FAIL ovf_first_pix: got %0d want %0d", pixel_out, img[0]); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit to;
    int bad_order = 0;
    for (int i = 0; i < NI; i++) img[i] = 8'($urandom);
    load_frame();
    run_frame(1'b1, 1'b0, 12, to);
    n_cmp++; if (to !== 1'b0 || pixel_out !== img[12]) begin n_bad++; $display("FAIL mid_pix12: got %0d want %0d", pixel_out, img[12]); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    n_cmp++; if ({pix_valid, busy, done} !== 3'b000 || res_count !== 4'd0) begin n_bad++; $display("FAIL mid_abort: got %b/%0d want 000/0", {pix_valid, busy, done}, res_count); end
    res_valid = 1'b1; conv_out = 32'sd3; @(negedge clk); res_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL mid_idle_ovf: got %b want 1", overflow); end
    run_frame(1'b0, 1'b0, -1, to);
    for (int i = 0; i < streamed.size() && i < NI; i++) if (streamed[i] != int'(img[i])) bad_order++;
    n_cmp++; if (to !== 1'b0 || streamed.size() != NI || bad_order != 0) begin n_bad++; $display("FAIL mid_restream: got %0d xfers %0d misordered want %0d 0", streamed.size(), bad_order, NI); end
    n_cmp++; if ({done, overflow} !== 2'b10) begin n_bad++; $display("FAIL mid_done_flags: got %b want 10", {done, overflow}); end
    start = 1'b1; res_valid = 1'b1; conv_out = 32'sd5; @(negedge clk);
    start = 1'b0; res_valid = 1'b0;
    n_cmp++; if ({overflow, done, busy} !== 3'b101 || res_count !== 4'd0) begin n_bad++; $display("FAIL mid_start_res: got %b/%0d want 101/0", {overflow, done, busy}, res_count); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_busy_ignore();
    bit to;
    int bad_order = 0;
    for (int i = 0; i < NI; i++) img[i] = 8'($urandom);
    load_frame();
    run_frame(1'b1, 1'b1, -1, to);
    for (int i = 0; i < streamed.size() && i < NI; i++) if (streamed[i] != int'(img[i])) bad_order++;
    n_cmp++; if (to !== 1'b0 || streamed.size() != NI || bad_order != 0) begin n_bad++; $display("FAIL busy_noise_stream: got %0d xfers %0d misordered want %0d 0", streamed.size(), bad_order, NI); end
    run_frame(1'b0, 1'b0, -1, to);
    bad_order = 0;
    for (int i = 0; i < streamed.size() && i < NI; i++) if (streamed[i] != int'(img[i])) bad_order++;
    n_cmp++; if (to !== 1'b0 || streamed.size() != NI || bad_order != 0) begin n_bad++; $display("FAIL busy_mem_kept: got %0d xfers %0d misordered want %0d 0", streamed.size(), bad_order, NI); end
  endtask

  task automatic test_early_results();
    logic signed [31:0] rv [NO];
    int x = 0, bad_order = 0;
    for (int i = 0; i < NI; i++) img[i] = 8'($urandom);
    load_frame();
    pix_ready = 1'b0; start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < NO; i++) begin
      rv[i] = 32'($urandom);
      res_valid = 1'b1; conv_out = rv[i]; @(negedge clk);
    end
    res_valid = 1'b0;
    n_cmp++; if (res_count !== 4'(NO) || {busy, done} !== 2'b10) begin n_bad++; $display("FAIL early_count: got %0d/%b want %0d/10", res_count, {busy, done}, NO); end
    res_valid = 1'b1; conv_out = -32'sd7; @(negedge clk); res_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1 || res_count !== 4'(NO)) begin n_bad++; $display("FAIL early_ovf: got %b/%0d want 1/%0d", overflow, res_count, NO); end
    pix_ready = 1'b1;
    for (int g = 0; g < 60 && pix_valid; g++) begin
      if (x < NI && pixel_out !== img[x]) bad_order++;
      x++;
      @(negedge clk);
    end
    pix_ready = 1'b0;
    n_cmp++; if (x != NI || bad_order != 0) begin n_bad++; $display("FAIL early_xfers: got %0d xfers %0d misordered want %0d 0", x, bad_order, NI); end
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL early_direct_done: got %b want 10", {done, busy}); end
    for (int i = 0; i < NO; i++) begin
      rd_addr = 4'(i); @(negedge clk);
      n_cmp++; if (rd_data !== rv[i]) begin n_bad++; $display("FAIL early_buf[%0d]: got %0d want %0d", i, rd_data, rv[i]); end
    end
  endtask

  task automatic test_param6();
    logic [7:0] img6 [NI6];
    logic signed [31:0] r6 [NO6];
    int x = 0, bad_order = 0;
    for (int i = 0; i < NI6; i++) begin
      img6[i] = 8'($urandom);
      ld_en6 = 1'b1; ld_addr6 = 5'(i); ld_data6 = img6[i]; @(negedge clk);
    end
    ld_en6 = 1'b0;
    pix_ready6 = 1'b1; start6 = 1'b1; @(negedge clk); start6 = 1'b0;
    for (int g = 0; g < 80 && pix_valid6; g++) begin
      if (x < NI6 && pixel_out6 !== img6[x]) bad_order++;
      x++;
      @(negedge clk);
    end
    n_cmp++; if (x != NI6 || bad_order != 0) begin n_bad++; $display("FAIL p6_xfers: got %0d xfers %0d misordered want %0d 0", x, bad_order, NI6); end
    for (int i = 0; i < NO6; i++) begin
      n_cmp++; if (done6 !== 1'b0) begin n_bad++; $display("FAIL p6_early_done: got %b want 0 before result %0d", done6, i); end
      r6[i] = 32'($urandom);
      res_valid6 = 1'b1; conv_out6 = r6[i]; @(negedge clk);
    end
    res_valid6 = 1'b0;
    n_cmp++; if (done6 !== 1'b1 || res_count6 !== 4'(NO6) || overflow6 !== 1'b0) begin n_bad++; $display("FAIL p6_done: got %b/%0d/%b want 1/%0d/0", done6, res_count6, overflow6, NO6); end
    rd_addr6 = 3'd7; @(negedge clk);
    n_cmp++; if (rd_data6 !== r6[7]) begin n_bad++; $display("FAIL p6_rd7: got %0d want %0d", rd_data6, r6[7]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_midframe();
    test_busy_ignore();
    test_early_results();
    test_param6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
